// File: rtl/alu_sequencer_if.sv
// Handshake and datapath-control bundle between an instruction source,
// the alu_sequencer and the RegFile_Alu datapath.
interface alu_sequencer_if;
  logic [15:0] Instr;
  logic        InstrValid;
  logic        InstrReady;
  logic        Hold;
  logic [4:0]  Flags;
  logic [3:0]  RdestRegLoc;
  logic [3:0]  RsrcRegLoc;
  logic [4:0]  OpCode;
  logic [15:0] Imm;
  logic        Imm_s;
  logic        En;
  logic [4:0]  FlagReg;
  logic        Done;
  logic        Err;
  logic [15:0] RetireCount;

  // slave: the sequencer itself
  modport slave (
    input  Instr, InstrValid, Hold, Flags,
    output InstrReady, RdestRegLoc, RsrcRegLoc, OpCode, Imm, Imm_s,
           En, FlagReg, Done, Err, RetireCount
  );

  // master: instruction source plus datapath
  modport master (
    output Instr, InstrValid, Hold, Flags,
    input  InstrReady, RdestRegLoc, RsrcRegLoc, OpCode, Imm, Imm_s,
           En, FlagReg, Done, Err, RetireCount
  );
endinterface

// File: rtl/alu_sequencer.sv
// Four-state instruction sequencer for the RegFile_Alu datapath: accept,
// decode, execute (latch flags), writeback (write enable, retire count).
module alu_sequencer (
  input  logic            Clk,
  input  logic            Rst,
  alu_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  localparam logic [3:0] OP_CMP      = 4'd2;
  localparam logic [3:0] OP_LAST_LEG = 4'd9;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [4:0]  flag_q, flag_d;
  logic [15:0] retire_q, retire_d;

  logic [3:0]  op_field;
  logic        imm_bit;
  logic        illegal;
  logic        sext;
  logic [15:0] imm_ext;

  // Datapath controls are decoded straight from IR, so they stay stable
  // from DECODE through WB and keep their last values while IDLE.
  always_comb begin
    op_field = ir_q[15:12];
    imm_bit  = ir_q[7];
    illegal  = (op_field > OP_LAST_LEG);
    sext     = (op_field <= OP_CMP);
    imm_ext  = 16'h0000;
    if (imm_bit) begin
      imm_ext = sext ? {{9{ir_q[6]}}, ir_q[6:0]} : {9'b0, ir_q[6:0]};
    end
  end

  assign bus.RdestRegLoc = ir_q[11:8];
  assign bus.RsrcRegLoc  = imm_bit ? 4'd0 : ir_q[3:0];
  assign bus.OpCode      = {1'b0, op_field};
  assign bus.Imm         = imm_ext;
  assign bus.Imm_s       = imm_bit;
  assign bus.FlagReg     = flag_q;
  assign bus.RetireCount = retire_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      ir_q     <= 16'h0000;
      flag_q   <= 5'd0;
      retire_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      flag_q   <= flag_d;
      retire_q <= retire_d;
    end
  end

  // Hold freezes everything and masks the pulses; a WB stalled by Hold
  // simply replays once Hold falls, so the write happens exactly once.
  always_comb begin
    state_d        = state_q;
    ir_d           = ir_q;
    flag_d         = flag_q;
    retire_d       = retire_q;
    bus.InstrReady = 1'b0;
    bus.En         = 1'b0;
    bus.Done       = 1'b0;
    bus.Err        = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.InstrReady = !bus.Hold && !Rst;
        if (!bus.Hold && bus.InstrValid) begin
          ir_d    = bus.Instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (!bus.Hold) begin
          bus.Err = illegal;
          state_d = illegal ? IDLE : EXEC;
        end
      end
      EXEC: begin
        if (!bus.Hold) begin
          flag_d  = bus.Flags;
          state_d = WB;
        end
      end
      WB: begin
        if (!bus.Hold) begin
          bus.En   = (op_field != OP_CMP);
          bus.Done = 1'b1;
          retire_d = retire_q + 16'd1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed, table-driven bench for alu_sequencer plus hand-written
// sequences for Hold in WB, reset in EXEC, valid held high and counter wrap.
module tb_alu_sequencer;

  logic Clk = 1'b0;
  logic Rst;
  alu_sequencer_if bus ();

  alu_sequencer dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] instr;
    logic [4:0]  flags;
    logic        legal;
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic [4:0]  op;
    logic [15:0] imm;
    logic        imm_s;
    logic        en;
  } vec_t;

  vec_t        vecs [12];
  int          total = 0;
  int          passed = 0;
  logic [15:0] retired = 16'h0000;
  logic [4:0]  last_flags = 5'd0;
  int          done_cnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else passed++;
  endtask

  function automatic logic [31:0] ctl_now();
    return {2'b00, bus.RdestRegLoc, bus.RsrcRegLoc, bus.OpCode, bus.Imm, bus.Imm_s};
  endfunction

  function automatic logic [31:0] ctl_exp(input vec_t v);
    return {2'b00, v.rdest, v.rsrc, v.op, v.imm, v.imm_s};
  endfunction

  // Called at a falling edge with the sequencer expected to be IDLE.
  task automatic run_vec(input vec_t v);
    int n;
    bus.Instr      = v.instr;
    bus.Flags      = v.flags;
    bus.InstrValid = 1'b1;
    n = 0;
    while (bus.InstrReady !== 1'b1 && n < 10) begin
      @(negedge Clk);
      n++;
    end
    chk("ready_before_accept", bus.InstrReady, 1);
    @(negedge Clk);
    bus.InstrValid = 1'b0;
    chk("decode_err", bus.Err, !v.legal);
    chk("decode_en", bus.En, 0);
    chk("decode_done", bus.Done, 0);
    if (!v.legal) begin
      @(negedge Clk);
      chk("ready_after_err", bus.InstrReady, 1);
      chk("retire_after_err", bus.RetireCount, retired);
      chk("flags_kept_after_err", bus.FlagReg, last_flags);
      $display("instr %h illegal: Err seen, count %0d", v.instr, bus.RetireCount);
      return;
    end
    chk("decode_ctl", ctl_now(), ctl_exp(v));
    @(negedge Clk);
    chk("exec_en", bus.En, 0);
    chk("exec_ctl", ctl_now(), ctl_exp(v));
    @(negedge Clk);
    chk("wb_en", bus.En, v.en);
    chk("wb_done", bus.Done, 1);
    chk("wb_flagreg", bus.FlagReg, v.flags);
    chk("wb_ctl", ctl_now(), ctl_exp(v));
    retired++;
    last_flags = v.flags;
    @(negedge Clk);
    chk("idle_en", bus.En, 0);
    chk("idle_ready", bus.InstrReady, 1);
    chk("idle_retire", bus.RetireCount, retired);
    $display("instr %h retired: op %h rdest %h imm %h count %0d",
             v.instr, bus.OpCode, bus.RdestRegLoc, bus.Imm, bus.RetireCount);
  endtask

  initial begin
    //            instr     flags  legal rdest rsrc  op     imm       imm_s en
    vecs[0]  = '{16'h0081, 5'h01, 1'b1, 4'h0, 4'h0, 5'h00, 16'h0001, 1'b1, 1'b1};
    vecs[1]  = '{16'h01FF, 5'h02, 1'b1, 4'h1, 4'h0, 5'h00, 16'hFFFF, 1'b1, 1'b1};
    vecs[2]  = '{16'h2110, 5'h04, 1'b1, 4'h1, 4'h0, 5'h02, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{16'h3A85, 5'h08, 1'b1, 4'hA, 4'h0, 5'h03, 16'h0005, 1'b1, 1'b1};
    vecs[4]  = '{16'h72C0, 5'h10, 1'b1, 4'h2, 4'h0, 5'h07, 16'h0040, 1'b1, 1'b1};
    vecs[5]  = '{16'h1FC0, 5'h1F, 1'b1, 4'hF, 4'h0, 5'h01, 16'hFFC0, 1'b1, 1'b1};
    vecs[6]  = '{16'h9EFF, 5'h15, 1'b1, 4'hE, 4'h0, 5'h09, 16'h007F, 1'b1, 1'b1};
    vecs[7]  = '{16'h5C3A, 5'h0A, 1'b1, 4'hC, 4'hA, 5'h05, 16'h0000, 1'b0, 1'b1};
    vecs[8]  = '{16'hA000, 5'h1B, 1'b0, 4'h0, 4'h0, 5'h00, 16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{16'hF3FF, 5'h00, 1'b0, 4'h0, 4'h0, 5'h00, 16'h0000, 1'b0, 1'b0};
    vecs[10] = '{16'h6481, 5'h03, 1'b1, 4'h4, 4'h0, 5'h06, 16'h0001, 1'b1, 1'b1};
    vecs[11] = '{16'h8B47, 5'h11, 1'b1, 4'hB, 4'h7, 5'h08, 16'h0000, 1'b0, 1'b1};

    Rst            = 1'b1;
    bus.Hold       = 1'b0;
    bus.InstrValid = 1'b0;
    bus.Instr      = 16'h0000;
    bus.Flags      = 5'h00;
    #1;
    chk("reset_ready", bus.InstrReady, 0);
    chk("reset_en_done_err", {bus.En, bus.Done, bus.Err}, 0);
    chk("reset_ctl", ctl_now(), 0);
    chk("reset_flagreg", bus.FlagReg, 0);
    chk("reset_retire", bus.RetireCount, 0);
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Hold across WB: write deferred, then exactly one En pulse.
    bus.Instr = 16'h0081; bus.Flags = 5'h06; bus.InstrValid = 1'b1;
    @(negedge Clk); bus.InstrValid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    bus.Hold = 1'b1;
    #1;
    chk("hold_wb_en", bus.En, 0);
    chk("hold_wb_done", bus.Done, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      chk("hold_en", bus.En, 0);
      chk("hold_ready", bus.InstrReady, 0);
      chk("hold_retire", bus.RetireCount, retired);
    end
    @(negedge Clk);
    bus.Hold = 1'b0;
    #1;
    chk("hold_release_en", bus.En, 1);
    chk("hold_release_done", bus.Done, 1);
    retired++;
    @(negedge Clk);
    chk("hold_after_en", bus.En, 0);
    chk("hold_after_retire", bus.RetireCount, retired);
    $display("hold in WB: deferred write retired, count %0d", bus.RetireCount);

    // InstrValid held high: one accept per IDLE visit.
    bus.Instr = 16'h0081; bus.InstrValid = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (bus.Done === 1'b1) done_cnt++;
    end
    bus.InstrValid = 1'b0;
    retired += 16'd2;
    chk("valid_high_dones", done_cnt, 2);
    chk("valid_high_retire", bus.RetireCount, retired);
    $display("valid held 8 cycles: %0d retirements", done_cnt);
    @(negedge Clk);
    chk("valid_high_idle_en", bus.En, 0);

    // Reset in EXEC: everything clears without a clock edge.
    bus.Instr = 16'h3A85; bus.Flags = 5'h1F; bus.InstrValid = 1'b1;
    @(negedge Clk); bus.InstrValid = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    chk("rst_exec_en", bus.En, 0);
    chk("rst_exec_ready", bus.InstrReady, 0);
    chk("rst_exec_ctl", ctl_now(), 0);
    chk("rst_exec_flagreg", bus.FlagReg, 0);
    chk("rst_exec_retire", bus.RetireCount, 0);
    $display("reset in EXEC: outputs cleared asynchronously");
    @(negedge Clk);
    Rst = 1'b0;
    retired = 16'h0000;
    last_flags = 5'd0;
    @(negedge Clk);
    run_vec(vecs[0]);

    // Counter wrap from 16'hFFFF.
    force dut.retire_q = 16'hFFFF;
    #1;
    release dut.retire_q;
    @(negedge Clk);
    chk("preset_retire", bus.RetireCount, 16'hFFFF);
    retired = 16'hFFFF;
    run_vec(vecs[3]);
    chk("wrap_retire_zero", bus.RetireCount, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

endmodule
